fpu_mult_arbiter: RTL

- Shares one FPU_Multiplication_Function instance between N_REQ requesters.
- Arbitrates round-robin and latches the winner's operands and round mode.
- Sequences the FPU's beg_FSM/rst_FSM handshake, captures result and flags, and returns them to the winner.
- Sits between the datapath clients and the multiplier core; the multiplier is unchanged.

---
 rtl/fpu_mult_arbiter.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/fpu_mult_arbiter.sv
// fpu_mult_arbiter
// ----------------
// Shares one FPU_Multiplication_Function core between N_REQ requesters.
// A round-robin pick in IDLE accepts one request, the winner's operands and
// round mode are latched onto the FPU inputs, the beg_FSM/rst_FSM handshake
// is sequenced, and the FPU result and flags are returned to the winner with
// a one-cycle rsp_valid pulse.
//
// Optional build macro: FPU_MULT_TIMEOUT_EN
//   defined   : a WAIT-state watchdog aborts after TIMEOUT_CYC cycles and
//               answers the owner with rsp_error = 1 and a zero result.
//   undefined : WAIT waits for the FPU indefinitely, rsp_error is tied 0.
//
// Ports
//   clk, rst            : clock (rising edge), async active-low reset
//   req_valid/req_ready : per-requester request / one-hot accept (IDLE only)
//   req_data_x/_y       : packed operands, requester i at [i*W +: W]
//   req_round           : packed round modes, requester i at [2i +: 2]
//   rsp_valid           : one-hot response pulse to the owner
//   rsp_result/_overflow/_underflow/_error : held until the next response
//   busy                : high in every state except IDLE
//   fpu_*               : connection to the multiplier core
module fpu_mult_arbiter #(
  parameter int W           = 32,
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_data_x,
  input  logic [N_REQ*W-1:0] req_data_y,
  input  logic [2*N_REQ-1:0] req_round,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_result,
  output logic               rsp_overflow,
  output logic               rsp_underflow,
  output logic               rsp_error,
  output logic               busy,
  output logic               fpu_beg_FSM,
  output logic               fpu_rst_FSM,
  output logic [W-1:0]       fpu_Data_MX,
  output logic [W-1:0]       fpu_Data_MY,
  output logic [1:0]         fpu_round_mode,
  input  logic               fpu_ready_flag,
  input  logic               fpu_overflow_flag,
  input  logic               fpu_underflow_flag,
  input  logic [W-1:0]       fpu_F_ieee_result
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    ST_FLUSH = 3'd0,
    ST_IDLE  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4,
    ST_CLEAR = 3'd5,
    ST_RESP  = 3'd6
  } state_t;

  state_t state_r, state_s;

  logic [GW-1:0]    last_grant_r;
  logic [GW-1:0]    owner_r;
  logic [GW-1:0]    grant_idx_s;
  logic [GW-1:0]    scan_idx_s;
  logic             grant_found_s;
  logic [N_REQ-1:0] grant_s;
  logic             accept_s;
  logic             capture_s;
  logic             timeout_s;

  logic             fpu_rst_s;
  logic             fpu_beg_s;
  logic             busy_s;
  logic [N_REQ-1:0] rsp_valid_s;

  logic             fpu_rst_r;
  logic             fpu_beg_r;
  logic             busy_r;
  logic [N_REQ-1:0] rsp_valid_r;
  logic [W-1:0]     data_mx_r;
  logic [W-1:0]     data_my_r;
  logic [1:0]       round_r;
  logic [W-1:0]     result_r;
  logic             overflow_r;
  logic             underflow_r;

  // Round-robin pick: scan downwards so the candidate closest after
  // last_grant is written last and therefore wins.
  always_comb begin
    grant_idx_s   = last_grant_r;
    grant_found_s = 1'b0;
    scan_idx_s    = last_grant_r;
    for (int k = N_REQ; k >= 1; k--) begin
      scan_idx_s    = GW'((int'(last_grant_r) + k) % N_REQ);
      grant_idx_s   = req_valid[scan_idx_s] ? scan_idx_s : grant_idx_s;
      grant_found_s = grant_found_s | req_valid[scan_idx_s];
    end
    grant_s              = {N_REQ{1'b0}};
    grant_s[grant_idx_s] = grant_found_s;
  end

  assign req_ready = (state_r == ST_IDLE) ? grant_s : {N_REQ{1'b0}};
  assign accept_s  = (state_r == ST_IDLE) && grant_found_s;

`ifdef FPU_MULT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wait_cnt_r;
  logic          rsp_error_r;
`endif

  // Next-state decode plus the next values of the registered FSM outputs.
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      ST_FLUSH: begin
        if (!fpu_ready_flag) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_FLUSH;
        end
      end
      ST_IDLE: begin
        if (grant_found_s) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD:  state_s = ST_START;
      ST_START: state_s = ST_WAIT;
      ST_WAIT: begin
        if (fpu_ready_flag) begin
          state_s   = ST_CLEAR;
          capture_s = 1'b1;
        end else begin
`ifdef FPU_MULT_TIMEOUT_EN
          // Counter starts at 0 on the first WAIT cycle, so this fires on
          // the TIMEOUT_CYC-th WAIT cycle without a ready flag.
          if (wait_cnt_r == CW'(TIMEOUT_CYC - 1)) begin
            state_s   = ST_CLEAR;
            timeout_s = 1'b1;
          end else begin
            state_s = ST_WAIT;
          end
`else
          state_s = ST_WAIT;
`endif
        end
      end
      ST_CLEAR: begin
        if (!fpu_ready_flag) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_CLEAR;
        end
      end
      ST_RESP:  state_s = ST_IDLE;
      default:  state_s = ST_FLUSH;
    endcase

    // Outputs are registered from the next state so they line up with it.
    fpu_rst_s              = (state_s == ST_FLUSH) || (state_s == ST_CLEAR);
    fpu_beg_s              = (state_s == ST_START);
    busy_s                 = (state_s != ST_IDLE);
    rsp_valid_s            = {N_REQ{1'b0}};
    rsp_valid_s[owner_r]   = (state_s == ST_RESP);
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_FLUSH;
      fpu_rst_r   <= 1'b1;
      fpu_beg_r   <= 1'b0;
      busy_r      <= 1'b1;
      rsp_valid_r <= {N_REQ{1'b0}};
    end else begin
      state_r     <= state_s;
      fpu_rst_r   <= fpu_rst_s;
      fpu_beg_r   <= fpu_beg_s;
      busy_r      <= busy_s;
      rsp_valid_r <= rsp_valid_s;
    end
  end

  // Operand latch on accept and result capture on FPU ready or watchdog.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_mx_r    <= {W{1'b0}};
      data_my_r    <= {W{1'b0}};
      round_r      <= 2'b00;
      owner_r      <= {GW{1'b0}};
      last_grant_r <= GW'(N_REQ - 1);
      result_r     <= {W{1'b0}};
      overflow_r   <= 1'b0;
      underflow_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        data_mx_r    <= req_data_x[grant_idx_s*W +: W];
        data_my_r    <= req_data_y[grant_idx_s*W +: W];
        round_r      <= req_round[grant_idx_s*2 +: 2];
        owner_r      <= grant_idx_s;
        last_grant_r <= grant_idx_s;
      end
      if (capture_s) begin
        result_r    <= fpu_F_ieee_result;
        overflow_r  <= fpu_overflow_flag;
        underflow_r <= fpu_underflow_flag;
      end else if (timeout_s) begin
        result_r    <= {W{1'b0}};
        overflow_r  <= 1'b0;
        underflow_r <= 1'b0;
      end
    end
  end

`ifdef FPU_MULT_TIMEOUT_EN
  // WAIT-cycle counter and the error flag returned with the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_r  <= {CW{1'b0}};
      rsp_error_r <= 1'b0;
    end else begin
      if (state_r != ST_WAIT) begin
        wait_cnt_r <= {CW{1'b0}};
      end else begin
        wait_cnt_r <= wait_cnt_r + CW'(1);
      end
      if (capture_s) begin
        rsp_error_r <= 1'b0;
      end else if (timeout_s) begin
        rsp_error_r <= 1'b1;
      end
    end
  end

  assign rsp_error = rsp_error_r;
`else
  assign rsp_error = 1'b0;
`endif

  assign rsp_valid      = rsp_valid_r;
  assign rsp_result     = result_r;
  assign rsp_overflow   = overflow_r;
  assign rsp_underflow  = underflow_r;
  assign busy           = busy_r;
  assign fpu_beg_FSM    = fpu_beg_r;
  assign fpu_rst_FSM    = fpu_rst_r;
  assign fpu_Data_MX    = data_mx_r;
  assign fpu_Data_MY    = data_my_r;
  assign fpu_round_mode = round_r;

endmodule
